// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous single-port data memory between the GPP and the comms processor.
// Build option DMEM_ARB_FAIR_EN: alternate grants on contention; undefined gives strict GPP priority.
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              gpp_req,
  input  logic              gpp_we,
  input  logic [ADDR_W-1:0] gpp_addr,
  input  logic [DATA_W-1:0] gpp_wdata,
  input  logic              gpp_lock,

  input  logic              cp_req,
  input  logic              cp_we,
  input  logic [ADDR_W-1:0] cp_addr,
  input  logic [DATA_W-1:0] cp_wdata,

  output logic              gpp_gnt,
  output logic              cp_gnt,
  output logic              gpp_rvalid,
  output logic              cp_rvalid,
  output logic [DATA_W-1:0] rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state   | meaning
  // IDLE    | no access this cycle, memory port driven to zero
  // GNT_GPP | GPP access presented to memory this cycle
  // GNT_CP  | CP access presented to memory this cycle
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_GPP = 2'd1,
    GNT_CP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              gpp_rvalid_q, cp_rvalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (gpp_req)     state_d = GNT_GPP;
        else if (cp_req) state_d = GNT_CP;
      end
      GNT_GPP: begin
        if (gpp_lock && gpp_req) state_d = GNT_GPP;
`ifdef DMEM_ARB_FAIR_EN
        else if (cp_req)         state_d = GNT_CP;
        else if (gpp_req)        state_d = GNT_GPP;
`else
        else if (gpp_req)        state_d = GNT_GPP;
        else if (cp_req)         state_d = GNT_CP;
`endif
      end
      GNT_CP: begin
        if (gpp_req)     state_d = GNT_GPP;
        else if (cp_req) state_d = GNT_CP;
      end
      default: state_d = IDLE;
    endcase
  end

  // The winner's access is captured at the grant edge so the requester may
  // present its next access during the grant cycle without disturbing this one.
  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    we_d    = 1'b0;
    case (state_d)
      GNT_GPP: begin
        addr_d  = gpp_addr;
        wdata_d = gpp_wdata;
        we_d    = gpp_we;
      end
      GNT_CP: begin
        addr_d  = cp_addr;
        wdata_d = cp_wdata;
        we_d    = cp_we;
      end
      default: begin
        addr_d  = '0;
        wdata_d = '0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpp_rvalid_q <= 1'b0;
      cp_rvalid_q  <= 1'b0;
    end else begin
      gpp_rvalid_q <= (state_q == GNT_GPP) && !we_q;
      cp_rvalid_q  <= (state_q == GNT_CP) && !we_q;
    end
  end

  assign gpp_gnt    = (state_q == GNT_GPP);
  assign cp_gnt     = (state_q == GNT_CP);
  assign gpp_rvalid = gpp_rvalid_q;
  assign cp_rvalid  = cp_rvalid_q;
  assign rdata      = mem_rdata;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural synchronous memory.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        gpp_req = 1'b0, gpp_we = 1'b0, gpp_lock = 1'b0;
  logic [15:0] gpp_addr = '0, gpp_wdata = '0;
  logic        cp_req = 1'b0, cp_we = 1'b0;
  logic [15:0] cp_addr = '0, cp_wdata = '0;
  logic        gpp_gnt, cp_gnt, gpp_rvalid, cp_rvalid, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .gpp_req(gpp_req), .gpp_we(gpp_we), .gpp_addr(gpp_addr), .gpp_wdata(gpp_wdata),
    .gpp_lock(gpp_lock),
    .cp_req(cp_req), .cp_we(cp_we), .cp_addr(cp_addr), .cp_wdata(cp_wdata),
    .gpp_gnt(gpp_gnt), .cp_gnt(cp_gnt), .gpp_rvalid(gpp_rvalid), .cp_rvalid(cp_rvalid),
    .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [7:0] idx);
    return {idx, idx} ^ 16'h5A3C;
  endfunction

  // behavioural memory: synchronous read, one cycle latency
  logic [15:0] mem [256];
  bit          mem_set [256];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:0]]     <= mem_wdata;
      mem_set[mem_addr[7:0]] <= 1'b1;
    end
    mem_rdata <= mem_set[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
  end

  typedef struct packed {
    logic        is_cp;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  function automatic acc_t mk(input logic is_cp, input logic we,
                              input logic [15:0] addr, input logic [15:0] wdata);
    acc_t a;
    a.is_cp = is_cp; a.we = we; a.addr = addr; a.wdata = wdata;
    return a;
  endfunction

  acc_t exp_q[$];
  acc_t g_list[8];
  acc_t c_list[8];
  int   g_n = 0, c_n = 0, g_lock_n = 0;

  // expected memory contents, updated one cycle after a write grant survives
  logic [15:0] model [256];
  bit          model_set [256];
  bit          pend_g = 0, pend_c = 0, wr_pend = 0;
  logic [15:0] pend_data = '0, wr_val = '0;
  logic [7:0]  wr_idx = '0;

  always @(negedge clk) begin
    acc_t e;
    if (!rst) begin
      pend_g  = 1'b0;
      pend_c  = 1'b0;
      wr_pend = 1'b0;
    end
    if (wr_pend) begin
      model[wr_idx]     = wr_val;
      model_set[wr_idx] = 1'b1;
      wr_pend           = 1'b0;
    end
    chk("gpp_rvalid", 32'(gpp_rvalid), 32'(pend_g));
    chk("cp_rvalid", 32'(cp_rvalid), 32'(pend_c));
    if (pend_g || pend_c) chk("rdata", 32'(rdata), 32'(pend_data));
    chk("gnt_excl", 32'(gpp_gnt & cp_gnt), 32'd0);
    pend_g = 1'b0;
    pend_c = 1'b0;
    if (gpp_gnt || cp_gnt) begin
      if (exp_q.size() == 0) begin
        chk("unexp_gnt", 32'({gpp_gnt, cp_gnt}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("gnt_port", 32'(cp_gnt), 32'(e.is_cp));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.we) begin
          chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
          wr_pend = 1'b1;
          wr_idx  = e.addr[7:0];
          wr_val  = e.wdata;
        end else begin
          pend_data = model_set[e.addr[7:0]] ? model[e.addr[7:0]] : init_val(e.addr[7:0]);
          if (e.is_cp) pend_c = 1'b1;
          else         pend_g = 1'b1;
        end
      end
    end else begin
      chk("idle_mem_we", 32'(mem_we), 32'd0);
      chk("idle_mem_addr", 32'(mem_addr), 32'd0);
    end
  end

  task automatic apply(input int gi, input int ci);
    gpp_req  = (gi < g_n);
    gpp_lock = (gi < g_lock_n);
    if (gi < g_n) begin
      gpp_we = g_list[gi].we; gpp_addr = g_list[gi].addr; gpp_wdata = g_list[gi].wdata;
    end
    cp_req = (ci < c_n);
    if (ci < c_n) begin
      cp_we = c_list[ci].we; cp_addr = c_list[ci].addr; cp_wdata = c_list[ci].wdata;
    end
  endtask

  // each requester holds req until granted, then presents its next access or drops req
  task automatic run_lists();
    int gi = 0, ci = 0, cyc = 0;
    apply(0, 0);
    while ((gi < g_n || ci < c_n) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (gpp_gnt) gi++;
      if (cp_gnt)  ci++;
      apply(gi, ci);
    end
    if (gi < g_n || ci < c_n) chk("list_timeout", 32'(gi + ci), 32'(g_n + c_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_gpp_gnt", 32'(gpp_gnt), 32'd0);
    chk("rst_cp_gnt", 32'(cp_gnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b1;

    // single GPP read
    @(negedge clk);
    gpp_req = 1'b1; gpp_we = 1'b0; gpp_addr = 16'h0010;
    exp_q.push_back(mk(1'b0, 1'b0, 16'h0010, 16'h0000));
    @(negedge clk);
    chk("rd_lat_gnt", 32'(gpp_gnt), 32'd1);
    chk("rd_lat_addr", 32'(mem_addr), 32'h0010);
    gpp_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", 32'(gpp_rvalid), 32'd1);
    repeat (2) @(negedge clk);

    // contention, both sides hold requests for 4 accesses each
    for (int i = 0; i < 4; i++) begin
      g_list[i] = mk(1'b0, 1'b0, 16'h0020 + 16'(i), 16'h0000);
      c_list[i] = mk(1'b1, 1'b1, 16'h0040 + 16'(i), 16'hC000 + 16'(i));
    end
    g_n = 4; c_n = 4; g_lock_n = 0;
`ifdef DMEM_ARB_FAIR_EN
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(g_list[i]);
      exp_q.push_back(c_list[i]);
    end
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(g_list[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(c_list[i]);
`endif
    run_lists();
    repeat (2) @(negedge clk);

    // locked read-modify-write by GPP while CP waits
    g_list[0] = mk(1'b0, 1'b0, 16'h0041, 16'h0000);
    g_list[1] = mk(1'b0, 1'b1, 16'h0041, 16'h1234);
    g_list[2] = mk(1'b0, 1'b0, 16'h0041, 16'h0000);
    c_list[0] = mk(1'b1, 1'b0, 16'h0010, 16'h0000);
    g_n = 3; c_n = 1; g_lock_n = 3;
    for (int i = 0; i < 3; i++) exp_q.push_back(g_list[i]);
    exp_q.push_back(c_list[0]);
    run_lists();
    g_lock_n = 0;
    repeat (2) @(negedge clk);

    // CP write
    c_list[0] = mk(1'b1, 1'b1, 16'h0200, 16'hBEEF);
    g_n = 0; c_n = 1;
    exp_q.push_back(c_list[0]);
    run_lists();
    @(negedge clk);
    chk("cp_wr_no_rvalid", 32'(cp_rvalid), 32'd0);
    @(negedge clk);

    // reset asserted in the middle of a CP grant cycle (write, then read)
    for (int w = 1; w >= 0; w--) begin
      cp_req = 1'b1; cp_we = 1'(w); cp_addr = 16'h0300; cp_wdata = 16'hDEAD;
      exp_q.push_back(mk(1'b1, 1'(w), 16'h0300, 16'hDEAD));
      @(negedge clk);
      chk("rst_pre_gnt", 32'(cp_gnt), 32'd1);
      cp_req = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("rst_async_gnt", 32'(cp_gnt), 32'd0);
      chk("rst_async_we", 32'(mem_we), 32'd0);
      chk("rst_async_addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      chk("rst_no_rvalid", 32'(cp_rvalid), 32'd0);
      gpp_req = 1'b1; gpp_we = 1'b0; gpp_addr = 16'h0300;
      exp_q.push_back(mk(1'b0, 1'b0, 16'h0300, 16'h0000));
      #2 rst = 1'b1;
      @(negedge clk);
      chk("post_rst_gnt", 32'(gpp_gnt), 32'd1);
      gpp_req = 1'b0;
      repeat (2) @(negedge clk);
    end

    // idle
    repeat (10) begin
      @(negedge clk);
      chk("idle_gnt", 32'({gpp_gnt, cp_gnt}), 32'd0);
      chk("idle_rvalid", 32'({gpp_rvalid, cp_rvalid}), 32'd0);
    end

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
